// File: rtl/mod_multicycle_control_pkg.sv
// rtl/mod_multicycle_control_pkg.sv - opcode, funct, ALU, state and trap-cause codes for the multi-cycle controller
package mod_multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_NOP = 3'b101;

  localparam logic [1:0] CAUSE_NONE   = 2'b00;
  localparam logic [1:0] CAUSE_OPCODE = 2'b01;
  localparam logic [1:0] CAUSE_FUNCT  = 2'b10;
  localparam logic [1:0] CAUSE_BUS    = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_R_EXEC, S_R_WB, S_BRANCH, S_JUMP, S_I_EXEC, S_I_WB, S_TRAP
  } state_e;

endpackage

// File: rtl/mod_multicycle_control_alu_decoder.sv
// rtl/mod_multicycle_control_alu_decoder.sv - R-type funct to ALU operation, flags unsupported funct codes
module mod_alu_decoder
  import mod_multicycle_control_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       illegal
);

  always_comb begin
    alu_op  = ALU_NOP;
    illegal = 1'b0;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mod_multicycle_control.sv
// rtl/mod_multicycle_control.sv - multi-cycle MIPS main controller with bus-timeout/illegal traps and retire counter
module mod_multicycle_control
  import mod_multicycle_control_pkg::*;
#(
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32,
  parameter bit EN_ADDI     = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                instr_done,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [CNT_W-1:0]    retired_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q;
  logic [1:0]         cause_q, cause_d;
  logic [CNT_W-1:0]   cnt_q;

  logic [2:0] r_alu_op;
  logic       r_illegal;
  logic       timeout, mem_state;

  logic       pc_write_r, i_or_d_r, mem_read_r, mem_write_r, ir_write_r;
  logic       reg_dst_r, mem_to_reg_r, reg_write_r, src_a_r, done_r, trap_r;
  logic [1:0] pc_src_r, src_b_r;
  logic [2:0] alu_r;

  mod_alu_decoder u_alu_dec (
    .funct   (funct),
    .alu_op  (r_alu_op),
    .illegal (r_illegal)
  );

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
  assign timeout   = (MEM_TIMEOUT != 0) && mem_state && !mem_ready &&
                     (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;     cause_d = cause_q;
    pc_write_r = 1'b0;     pc_src_r = 2'b00;      i_or_d_r = 1'b0;
    mem_read_r = 1'b0;     mem_write_r = 1'b0;    ir_write_r = 1'b0;
    reg_dst_r = 1'b0;      mem_to_reg_r = 1'b0;   reg_write_r = 1'b0;
    src_a_r = 1'b0;        src_b_r = 2'b00;       alu_r = ALU_NOP;
    done_r = 1'b0;         trap_r = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_r = !timeout;
        src_b_r    = 2'b01;
        alu_r      = ALU_ADD;
        if (mem_ready) begin
          ir_write_r = 1'b1;
          pc_write_r = 1'b1;
          state_d    = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_BUS;
        end
      end
      S_DECODE: begin
        src_b_r = 2'b11;
        alu_r   = ALU_ADD;
        if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEM_ADDR;
        else if (opcode == OP_RTYPE) begin
          if (r_illegal) begin
            state_d = S_TRAP;
            cause_d = CAUSE_FUNCT;
          end else state_d = S_R_EXEC;
        end
        else if (opcode == OP_BEQ) state_d = S_BRANCH;
        else if (opcode == OP_J) state_d = S_JUMP;
        else if (EN_ADDI && opcode == OP_ADDI) state_d = S_I_EXEC;
        else begin
          state_d = S_TRAP;
          cause_d = CAUSE_OPCODE;
        end
      end
      S_MEM_ADDR: begin
        src_a_r = 1'b1;
        src_b_r = 2'b10;
        alu_r   = ALU_ADD;
        state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read_r = !timeout;
        i_or_d_r   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
        else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_BUS;
        end
      end
      S_MEM_WB: begin
        reg_write_r  = 1'b1;
        mem_to_reg_r = 1'b1;
        done_r       = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write_r = !timeout;
        i_or_d_r    = 1'b1;
        if (mem_ready) begin
          done_r  = 1'b1;
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_BUS;
        end
      end
      S_R_EXEC: begin
        src_a_r = 1'b1;
        alu_r   = r_alu_op;
        state_d = S_R_WB;
      end
      S_R_WB: begin
        reg_dst_r   = 1'b1;
        reg_write_r = 1'b1;
        done_r      = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        src_a_r    = 1'b1;
        alu_r      = ALU_SUB;
        pc_src_r   = 2'b01;
        pc_write_r = zero;
        done_r     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_src_r   = 2'b10;
        pc_write_r = 1'b1;
        done_r     = 1'b1;
        state_d    = S_FETCH;
      end
      S_I_EXEC: begin
        src_a_r = 1'b1;
        src_b_r = 2'b10;
        alu_r   = ALU_ADD;
        state_d = S_I_WB;
      end
      S_I_WB: begin
        reg_write_r = 1'b1;
        done_r      = 1'b1;
        state_d     = S_FETCH;
      end
      S_TRAP: begin
        pc_src_r   = 2'b11;
        pc_write_r = 1'b1;
        trap_r     = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cause_q <= CAUSE_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      // Every memory state is entered from a different state, so a state change marks entry.
      if (state_d != state_q) wait_q <= '0;
      else if (mem_state && !mem_ready) wait_q <= wait_q + WAIT_W'(1);
      if (done_r) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Reset overrides the decode so no strobe reaches the datapath while rst_n is low.
  assign pc_write    = rst_n & pc_write_r;
  assign pc_src      = rst_n ? pc_src_r : 2'b00;
  assign i_or_d      = rst_n & i_or_d_r;
  assign mem_read    = rst_n & mem_read_r;
  assign mem_write   = rst_n & mem_write_r;
  assign ir_write    = rst_n & ir_write_r;
  assign reg_dst     = rst_n & reg_dst_r;
  assign mem_to_reg  = rst_n & mem_to_reg_r;
  assign reg_write   = rst_n & reg_write_r;
  assign alu_src_a   = rst_n & src_a_r;
  assign alu_src_b   = rst_n ? src_b_r : 2'b00;
  assign alu_op      = ALU_OP_W'(rst_n ? alu_r : ALU_NOP);
  assign instr_done  = rst_n & done_r;
  assign trap        = rst_n & trap_r;
  assign trap_cause  = cause_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_mod_multicycle_control.sv
// tb/tb_mod_multicycle_control.sv - directed self-checking bench for mod_multicycle_control
module tb_mod_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode, funct;
  logic        zero, mem_ready;
  logic        pc_write, i_or_d, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a, instr_done, trap;
  logic [1:0]  pc_src, alu_src_b, trap_cause;
  logic [2:0]  alu_op;
  logic [31:0] retired_cnt;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  mod_multicycle_control #(
    .ALU_OP_W(3), .MEM_TIMEOUT(4), .CNT_W(32), .EN_ADDI(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .instr_done(instr_done), .trap(trap),
    .trap_cause(trap_cause), .retired_cnt(retired_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = 6'h00; funct = 6'h20; zero = 1'b0; mem_ready = 1'b1;
    #3;
    check("rst_mem_read", mem_read, 0);
    check("rst_pc_write", pc_write, 0);
    check("rst_ir_write", ir_write, 0);
    check("rst_alu_op", alu_op, 3'b101);
    check("rst_cause", trap_cause, 0);
    check("rst_retired", retired_cnt, 0);
    tick(); tick();
    #2 rst_n = 1'b1;
    #1;

    // add: FETCH, DECODE, R_EXEC, R_WB
    check("add_f_mem_read", mem_read, 1);
    check("add_f_ir_write", ir_write, 1);
    check("add_f_pc_write", pc_write, 1);
    check("add_f_alu", alu_op, 3'b010);
    check("add_f_src_b", alu_src_b, 2'b01);
    check("add_f_reg_write", reg_write, 0);
    tick();
    check("add_d_src_b", alu_src_b, 2'b11);
    check("add_d_mem_read", mem_read, 0);
    check("add_d_reg_write", reg_write, 0);
    tick();
    check("add_x_src_a", alu_src_a, 1);
    check("add_x_src_b", alu_src_b, 2'b00);
    check("add_x_alu", alu_op, 3'b010);
    check("add_x_reg_write", reg_write, 0);
    funct = 6'h2A; #1;
    check("slt_x_alu", alu_op, 3'b111);
    funct = 6'h22; #1;
    check("sub_x_alu", alu_op, 3'b110);
    tick();
    check("add_wb_reg_write", reg_write, 1);
    check("add_wb_reg_dst", reg_dst, 1);
    check("add_wb_done", instr_done, 1);
    tick();
    check("add_retired", retired_cnt, 1);
    check("add_back_fetch", mem_read, 1);

    // lw with 3 wait cycles in MEM_READ; 4th cycle has ready at the timeout limit
    opcode = 6'h23;
    tick();
    tick();
    check("lw_ma_src_a", alu_src_a, 1);
    check("lw_ma_src_b", alu_src_b, 2'b10);
    check("lw_ma_alu", alu_op, 3'b010);
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lw_wait_mem_read", mem_read, 1);
      check("lw_wait_i_or_d", i_or_d, 1);
      check("lw_wait_trap", trap, 0);
      tick();
    end
    mem_ready = 1'b1; #1;
    check("lw_ready_mem_read", mem_read, 1);
    tick();
    check("lw_wb_reg_write", reg_write, 1);
    check("lw_wb_mem_to_reg", mem_to_reg, 1);
    check("lw_wb_reg_dst", reg_dst, 0);
    check("lw_wb_done", instr_done, 1);
    check("lw_wb_trap", trap, 0);
    tick();
    check("lw_retired", retired_cnt, 2);

    // sw
    opcode = 6'h2B;
    for (int i = 0; i < 3; i++) begin
      check("sw_reg_write", reg_write, 0);
      tick();
    end
    check("sw_mem_write", mem_write, 1);
    check("sw_i_or_d", i_or_d, 1);
    check("sw_done", instr_done, 1);
    check("sw_reg_write_mw", reg_write, 0);
    tick();
    check("sw_retired", retired_cnt, 3);

    // beq not taken then taken
    opcode = 6'h04; zero = 1'b0;
    tick(); tick();
    check("beq0_pc_write", pc_write, 0);
    check("beq0_pc_src", pc_src, 2'b01);
    check("beq0_alu", alu_op, 3'b110);
    check("beq0_done", instr_done, 1);
    tick(); tick(); tick();
    zero = 1'b1; #1;
    check("beq1_pc_write", pc_write, 1);
    check("beq1_pc_src", pc_src, 2'b01);
    tick();
    check("beq_retired", retired_cnt, 5);

    // j
    opcode = 6'h02;
    tick(); tick();
    check("j_pc_src", pc_src, 2'b10);
    check("j_pc_write", pc_write, 1);
    tick();
    check("j_retired", retired_cnt, 6);

    // addi
    opcode = 6'h08;
    tick(); tick();
    check("addi_x_src_b", alu_src_b, 2'b10);
    check("addi_x_alu", alu_op, 3'b010);
    tick();
    check("addi_wb_reg_write", reg_write, 1);
    check("addi_wb_mem_to_reg", mem_to_reg, 0);
    check("addi_wb_reg_dst", reg_dst, 0);
    tick();
    check("addi_retired", retired_cnt, 7);

    // illegal opcode, then illegal funct
    opcode = 6'h3F;
    tick(); tick();
    check("badop_trap", trap, 1);
    check("badop_cause", trap_cause, 2'b01);
    check("badop_pc_src", pc_src, 2'b11);
    check("badop_pc_write", pc_write, 1);
    check("badop_done", instr_done, 0);
    tick();
    check("badop_retired", retired_cnt, 7);
    opcode = 6'h00; funct = 6'h3F;
    tick(); tick();
    check("badfn_trap", trap, 1);
    check("badfn_cause", trap_cause, 2'b10);
    tick();

    // bus timeout in FETCH with MEM_TIMEOUT=4
    mem_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      check("to_fetch_mem_read", mem_read, 1);
      check("to_fetch_trap", trap, 0);
      tick();
    end
    tick();
    check("to_trap", trap, 1);
    check("to_cause", trap_cause, 2'b11);
    check("to_retired", retired_cnt, 7);
    mem_ready = 1'b1;
    tick();

    // reset pulse mid MEM_READ
    opcode = 6'h23;
    tick(); tick(); tick();
    mem_ready = 1'b0; #1;
    check("rst2_pre_mem_read", mem_read, 1);
    rst_n = 1'b0; #1;
    check("rst2_mem_read", mem_read, 0);
    check("rst2_i_or_d", i_or_d, 0);
    check("rst2_alu", alu_op, 3'b101);
    check("rst2_retired", retired_cnt, 0);
    check("rst2_cause", trap_cause, 0);
    tick();
    #2 rst_n = 1'b1; mem_ready = 1'b1; #1;
    check("rst2_fetch_mem_read", mem_read, 1);
    check("rst2_fetch_i_or_d", i_or_d, 0);
    check("rst2_fetch_ir_write", ir_write, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
